// File: rtl/trace_pkg.sv
// Shared constants, FSM encoding and entry-width helpers for out_trace_monitor.
// TRACE_TIMESTAMP_EN adds a TSW-bit timestamp field to every trace entry.
package trace_pkg;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_NCH      = 2;
  localparam int unsigned DEF_DEPTH    = 16;
  localparam int unsigned DEF_TSW      = 16;
  localparam int unsigned DEF_RST_HOLD = 4;

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  function automatic int unsigned chw_of(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Stored entry is {ts (optional), ch, data}
  function automatic int unsigned entry_w(input int unsigned width,
                                          input int unsigned chw,
                                          input int unsigned tsw);
    return width + chw + (TS_EN ? tsw : 0);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through trace FIFO with registered head, occupancy count
// and push acceptance while full when a pop happens in the same cycle.
module trace_fifo #(
  parameter  int unsigned EW    = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [EW-1:0] wdata,
  output logic          push_ok_c,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [EW-1:0] rd_entry,
  output logic [CW-1:0] count
);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW-1:0] rptr_d;
  logic          pop_c;
  logic [CW-1:0] count_d;
  logic [CW-1:0] rem_c;
  logic [EW-1:0] head_d;

  // Next head: the slot being written if nothing older survives the pop
  always_comb begin
    pop_c     = rd_valid && rd_ready;
    push_ok_c = push && ((count < CW'(DEPTH)) || pop_c);
    count_d   = count + CW'(push_ok_c) - CW'(pop_c);
    rem_c     = count - CW'(pop_c);
    rptr_d    = rptr_q + AW'(pop_c);
    head_d    = '0;
    if (rem_c == '0) begin
      if (push_ok_c) head_d = wdata;
    end else begin
      head_d = mem[rptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_entry <= '0;
    end else begin
      if (push_ok_c) wptr_q <= wptr_q + AW'(1);
      rptr_q   <= rptr_d;
      count    <= count_d;
      rd_valid <= (count_d != '0);
      rd_entry <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok_c) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/out_trace_monitor.sv
// Core reset sequencer plus per-channel change monitor feeding a trace FIFO.
// Define TRACE_TIMESTAMP_EN to record a RUN-cycle timestamp with each entry.
module out_trace_monitor
  import trace_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEF_WIDTH,
  parameter  int unsigned NCH      = DEF_NCH,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned TSW      = DEF_TSW,
  parameter  int unsigned RST_HOLD = DEF_RST_HOLD,
  localparam int unsigned CHW      = chw_of(NCH),
  localparam int unsigned CNTW     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 core_rst,
  input  logic [NCH*WIDTH-1:0] mon_in,
  input  logic                 mon_en,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WIDTH-1:0]     rd_data,
  output logic [CHW-1:0]       rd_ch,
  output logic [TSW-1:0]       rd_ts,
  output logic [CNTW-1:0]      count,
  output logic                 overflow
);

  localparam int unsigned EW  = entry_w(WIDTH, CHW, TSW);
  localparam int unsigned HCW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  logic [1:0]                 state_q, state_d;
  logic [HCW-1:0]             hold_q, hold_d;
  logic [NCH-1:0][WIDTH-1:0]  shadow_q;
  logic [NCH-1:0]             chg;
  logic [CHW-1:0]             sel_ch;
  logic [WIDTH-1:0]           sel_val;
  logic                       push_req;
  logic                       push_ok_c;
  logic [EW-1:0]              wdata;
  logic [EW-1:0]              head;

  // Reset sequencing: HOLD for RST_HOLD cycles, one ARMED cycle, then RUN
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_q == HCW'(RST_HOLD - 1)) begin
          state_d = ST_ARMED;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      ST_ARMED: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HOLD;
      hold_q   <= '0;
      core_rst <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      core_rst <= (state_d == ST_HOLD);
      overflow <= overflow | (push_req & ~push_ok_c);
    end
  end

  // Lowest-index changed channel wins the single capture slot this cycle
  always_comb begin
    chg     = '0;
    sel_ch  = '0;
    sel_val = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      chg[i] = (mon_in[i*WIDTH +: WIDTH] != shadow_q[i]);
    end
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (chg[i]) begin
        sel_ch  = CHW'(i);
        sel_val = mon_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign push_req = (state_q == ST_RUN) && mon_en && (|chg);

  // Shadows follow the bus wholesale when not capturing, else only the winner
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
    end else if ((state_q == ST_ARMED) || ((state_q == ST_RUN) && !mon_en)) begin
      shadow_q <= mon_in;
    end else if (push_req) begin
      shadow_q[sel_ch] <= sel_val;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TSW-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else if (state_q == ST_RUN) begin
      ts_q <= ts_q + TSW'(1);
    end
  end

  assign wdata = {ts_q, sel_ch, sel_val};
  assign rd_ts = head[WIDTH+CHW +: TSW];
`else
  assign wdata = {sel_ch, sel_val};
  assign rd_ts = '0;
`endif

  assign rd_data = head[WIDTH-1:0];
  assign rd_ch   = head[WIDTH +: CHW];

  trace_fifo #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .wdata     (wdata),
    .push_ok_c (push_ok_c),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_entry  (head),
    .count     (count)
  );

endmodule

// File: tb/tb_out_trace_monitor.sv
// Self-checking bench for out_trace_monitor: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_out_trace_monitor;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned NCH      = 2;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned TSW      = 16;
  localparam int unsigned RST_HOLD = 4;
  localparam int unsigned CHW      = 1;
  localparam int unsigned CNTW     = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 core_rst;
  logic [NCH*WIDTH-1:0] mon_in;
  logic                 mon_en;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [WIDTH-1:0]     rd_data;
  logic [CHW-1:0]       rd_ch;
  logic [TSW-1:0]       rd_ts;
  logic [CNTW-1:0]      count;
  logic                 overflow;

  always #5 clk = ~clk;

  out_trace_monitor #(
    .WIDTH    (WIDTH),
    .NCH      (NCH),
    .DEPTH    (DEPTH),
    .TSW      (TSW),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .core_rst (core_rst),
    .mon_in   (mon_in),
    .mon_en   (mon_en),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_ch    (rd_ch),
    .rd_ts    (rd_ts),
    .count    (count),
    .overflow (overflow)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int unsigned      ch;
    int unsigned      ts;
  } ent_t;

  ent_t             q[$];
  logic [WIDTH-1:0] sh [NCH];
  int               since = 0;
  bit               m_ovf = 1'b0;
  bit               m_valid = 1'b0;
  int               n_checks = 0;
  int               n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [WIDTH-1:0] chan(input int i);
    return mon_in[i*WIDTH +: WIDTH];
  endfunction

  function automatic int unsigned ts_exp(input int unsigned t);
`ifdef TRACE_TIMESTAMP_EN
    return t % (1 << TSW);
`else
    return 0;
`endif
  endfunction

  // Model: 'since' counts low-rst edges; cycle RST_HOLD is ARMED, later ones RUN
  always @(posedge clk) begin
    bit   pop;
    bit   push_ok;
    int   idx;
    ent_t e;
    if (rst) begin
      since = 0;
      q.delete();
      m_ovf = 1'b0;
      for (int i = 0; i < int'(NCH); i++) sh[i] = '0;
    end else begin
      pop     = (q.size() != 0) && rd_ready;
      push_ok = 1'b0;
      e.data  = '0;
      e.ch    = 0;
      e.ts    = 0;
      if (since == int'(RST_HOLD)) begin
        for (int i = 0; i < int'(NCH); i++) sh[i] = chan(i);
      end else if (since > int'(RST_HOLD)) begin
        if (!mon_en) begin
          for (int i = 0; i < int'(NCH); i++) sh[i] = chan(i);
        end else begin
          idx = -1;
          for (int i = 0; i < int'(NCH); i++)
            if (idx < 0 && chan(i) != sh[i]) idx = i;
          if (idx >= 0) begin
            e.data  = chan(idx);
            e.ch    = idx;
            e.ts    = ts_exp(since - RST_HOLD - 1);
            sh[idx] = e.data;
            if (q.size() < int'(DEPTH) || pop) push_ok = 1'b1;
            else m_ovf = 1'b1;
          end
        end
      end
      if (pop) void'(q.pop_front());
      if (push_ok) q.push_back(e);
      if (since < 1000000) since++;
    end
    m_valid = 1'b1;
  end

  // Compare process: every cycle, mid-period
  always @(negedge clk) begin
    if (m_valid) begin
      chk("core_rst", core_rst, since < int'(RST_HOLD));
      chk("rd_valid", rd_valid, q.size() != 0);
      chk("count", count, q.size());
      chk("overflow", overflow, m_ovf);
      if (q.size() != 0) begin
        chk("rd_data", rd_data, q[0].data);
        chk("rd_ch", rd_ch, q[0].ch);
        chk("rd_ts", rd_ts, q[0].ts);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] held;
    rst      = 1'b1;
    mon_en   = 1'b1;
    mon_in   = '0;
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_core_rst", core_rst, 1);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_ts", rd_ts, 0);

    // Release reset with a nonzero bus; ch0 baseline is 0
    mon_in = {32'h0000_0011, 32'h0000_0000};
    rst    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("hold_core_rst_%0d", k), core_rst, (k < 4) ? 1 : 0);
      chk($sformatf("hold_rd_valid_%0d", k), rd_valid, 0);
    end
    @(negedge clk);
    chk("armed_no_entry", rd_valid, 0);
    repeat (5) @(negedge clk);
    chk("idle_no_entry", count, 0);

    // Single change in RUN cycle 5
    mon_in[WIDTH-1:0] = 32'h0000_00AB;
    @(negedge clk);
    chk("single_valid", rd_valid, 1);
    chk("single_count", count, 1);
    chk("single_data", rd_data, 32'hAB);
    chk("single_ch", rd_ch, 0);
`ifdef TRACE_TIMESTAMP_EN
    chk("single_ts", rd_ts, 5);
`else
    chk("single_ts", rd_ts, 0);
`endif
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("single_popped", count, 0);

    // Simultaneous change on both channels
    mon_in = {32'h0000_00C1, 32'h0000_00C0};
    @(negedge clk);
    chk("simul_first_ch", rd_ch, 0);
    chk("simul_first_data", rd_data, 32'hC0);
    chk("simul_count1", count, 1);
    @(negedge clk);
    chk("simul_count2", count, 2);
    rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    rd_ready = 1'b0;
    chk("simul_drained", count, 0);

    // Overflow: 17 events into 16 slots
    for (int i = 0; i < 17; i++) begin
      mon_in[WIDTH-1:0] = 32'h100 + 32'(i);
      @(negedge clk);
    end
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    rd_ready = 1'b1;
    mon_in[WIDTH-1:0] = 32'h200;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("ovf_pushpop_count", count, 16);
    chk("ovf_pushpop_head", rd_data, 32'h101);
    rd_ready = 1'b1;
    repeat (16) @(negedge clk);
    rd_ready = 1'b0;
    chk("ovf_drained", count, 0);

    // Backpressure: ready 1,0,1
    for (int i = 0; i < 3; i++) begin
      mon_in[WIDTH-1:0] = 32'h300 + 32'(i);
      @(negedge clk);
    end
    chk("bp_count", count, 3);
    chk("bp_head0", rd_data, 32'h300);
    rd_ready = 1'b1;
    @(negedge clk);
    chk("bp_head1", rd_data, 32'h301);
    held = rd_data;
    rd_ready = 1'b0;
    @(negedge clk);
    chk("bp_stall_stable", rd_data, held);
    chk("bp_stall_count", count, 2);
    rd_ready = 1'b1;
    @(negedge clk);
    chk("bp_head2", rd_data, 32'h302);
    @(negedge clk);
    rd_ready = 1'b0;
    chk("bp_drained", count, 0);

    // mon_en low while ch1 changes: nothing logged on re-enable
    mon_en = 1'b0;
    mon_in[2*WIDTH-1:WIDTH] = 32'h400;
    @(negedge clk);
    mon_in[2*WIDTH-1:WIDTH] = 32'h401;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("en_no_stale", count, 0);

    // Reset pulse with 5 queued entries
    for (int i = 0; i < 5; i++) begin
      mon_in[WIDTH-1:0] = 32'h500 + 32'(i);
      @(negedge clk);
    end
    chk("rstp_pre_count", count, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstp_count", count, 0);
    chk("rstp_overflow", overflow, 0);
    chk("rstp_core_rst", core_rst, 1);
    chk("rstp_rd_valid", rd_valid, 0);

    // Randomized traffic with varying backpressure and rare resets
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 399) == 0);
      mon_en = ($urandom_range(0, 7) != 0);
      if (((i / 500) % 2) == 1) rd_ready = ($urandom_range(0, 3) == 0);
      else                      rd_ready = ($urandom_range(0, 1) == 1);
      for (int c = 0; c < int'(NCH); c++)
        if ($urandom_range(0, 2) == 0)
          mon_in[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 3));
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
